// File: rtl/unpacker.sv
// ---------------------------------------------------------------------------
// unpacker
//
// Receive-side counterpart of the RGB stream packer. It takes a 256-bit
// AXI4-Stream of tightly packed 24-bit pixels and re-forms it into 192-bit
// beats of 8 pixels each. Every three input words (96 bytes) become four
// output beats (32 pixels). The fourth beat of each group is built entirely
// from leftover bytes, so input is paused for one cycle while it goes out.
//
// Ports:
//   aclk, aresetn   clock; synchronous active-low reset
//   s_axis_tdata    packed stream word, byte k = tdata[8k+7:8k]
//   s_axis_tkeep    ignored, expected all ones
//   s_axis_tlast    last word of a line
//   s_axis_tuser    first word of a frame
//   s_axis_tvalid   input word valid
//   s_axis_tready   input word accepted when high together with tvalid
//   rgb_out         8 pixels, pixel p at [24p+23:24p], first byte in MSBs
//   out_valid       rgb_out beat valid
//   out_ready       downstream accepts the beat
//   out_sof         beat is the first of a frame
//   out_eol         beat is the last of a line
//   align_err       sticky flag, set on tuser/tlast at an unexpected phase
// ---------------------------------------------------------------------------
module unpacker (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [255:0] s_axis_tdata,
    input  logic [31:0]  s_axis_tkeep,
    input  logic         s_axis_tlast,
    input  logic         s_axis_tuser,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [191:0] rgb_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sof,
    output logic         out_eol,
    output logic         align_err
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [191:0] residue;
    logic [191:0] residue_next;
    logic         eol_pending;
    logic         eol_pending_next;

    // Beat window as a little-endian byte vector: byte b = window[8b+7:8b].
    logic [191:0] window;
    logic         beat_sof;
    logic         beat_eol;
    logic         update;
    logic         err_set;
    logic         accept;
    logic         out_free;

    // tkeep carries no information for this stream.
    logic         unused_tkeep;
    assign unused_tkeep = &{1'b0, s_axis_tkeep};

    // Byte window to pixel layout: the first byte of each pixel lands in the
    // pixel's most significant byte.
    function automatic logic [191:0] bytes_to_pixels(input logic [191:0] win);
        logic [191:0] px;
        px = '0;
        for (int p = 0; p < 8; p++) begin
            px[24*p+16 +: 8] = win[8*(3*p)   +: 8];
            px[24*p+8  +: 8] = win[8*(3*p+1) +: 8];
            px[24*p    +: 8] = win[8*(3*p+2) +: 8];
        end
        return px;
    endfunction

    always_comb begin
        out_free         = !out_valid || out_ready;
        s_axis_tready    = aresetn && (state != S3) && out_free;
        accept           = s_axis_tvalid && s_axis_tready;
        state_next       = state;
        residue_next     = residue;
        eol_pending_next = eol_pending;
        window           = '0;
        beat_sof         = 1'b0;
        beat_eol         = 1'b0;
        update           = 1'b0;
        err_set          = 1'b0;

        if (state == S3) begin
            if (out_free) begin
                update           = 1'b1;
                window           = residue;
                beat_eol         = eol_pending;
                eol_pending_next = 1'b0;
                state_next       = S0;
            end
        end else if (accept) begin
            update   = 1'b1;
            beat_sof = s_axis_tuser;
            // A frame start seen mid-group resynchronises: the word is
            // treated as the first of a group and the residue is dropped.
            if (s_axis_tuser && (state != S0)) begin
                err_set = 1'b1;
            end
            if (s_axis_tuser || (state == S0)) begin
                window       = s_axis_tdata[191:0];
                residue_next = {128'b0, s_axis_tdata[255:192]};
                state_next   = S1;
            end else if (state == S1) begin
                window       = {s_axis_tdata[127:0], residue[63:0]};
                residue_next = {64'b0, s_axis_tdata[255:128]};
                state_next   = S2;
            end else begin
                window           = {s_axis_tdata[63:0], residue[127:0]};
                residue_next     = s_axis_tdata[255:64];
                eol_pending_next = s_axis_tlast;
                state_next       = S3;
            end
            // A line ending before the third word of a group (judged after
            // any tuser resync) closes the line on this beat and restarts.
            if (s_axis_tlast && (s_axis_tuser || (state != S2))) begin
                err_set          = 1'b1;
                beat_eol         = 1'b1;
                residue_next     = '0;
                eol_pending_next = 1'b0;
                state_next       = S0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= S0;
            residue     <= '0;
            eol_pending <= 1'b0;
        end else begin
            state       <= state_next;
            residue     <= residue_next;
            eol_pending <= eol_pending_next;
        end
    end

    // Output register: loads only on an update; a beat that is taken with
    // nothing new behind it retires the valid flag.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rgb_out   <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            align_err <= 1'b0;
        end else begin
            if (update) begin
                rgb_out   <= bytes_to_pixels(window);
                out_sof   <= beat_sof;
                out_eol   <= beat_eol;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (err_set) begin
                align_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unpacker.sv
// ---------------------------------------------------------------------------
// tb_unpacker
//
// Self-checking bench for unpacker. The reference model treats the stream
// as a queue of bytes: each accepted word appends 32 bytes, each beat pops
// 24, and a word counter within the 3-word group decides the flags.
// ---------------------------------------------------------------------------
module tb_unpacker;

    logic         aclk;
    logic         aresetn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic         s_axis_tlast;
    logic         s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [191:0] rgb_out;
    logic         out_valid;
    logic         out_ready;
    logic         out_sof;
    logic         out_eol;
    logic         align_err;

    int checkCount = 0;
    int errorCount = 0;
    int cyc = 0;
    int readyMode = 0;
    bit monOn = 0;

    // Reference model state
    logic [7:0]   pend[$];
    int           mWordIdx = 0;
    logic         mErr = 1'b0;
    logic [191:0] expRgb[$];
    logic         expSof[$];
    logic         expEol[$];

    // Beats observed leaving the DUT, for directed checks
    logic [191:0] gotRgb[$];
    logic         gotSof[$];
    logic         gotEol[$];
    int           accCycles[$];

    logic         stallPrev = 1'b0;
    logic [193:0] prevOut = '0;

    unpacker dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .rgb_out       (rgb_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sof       (out_sof),
        .out_eol       (out_eol),
        .align_err     (align_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc = cyc + 1;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] mkWord(input int base);
        logic [255:0] w;
        for (int j = 0; j < 32; j++) w[8*j +: 8] = 8'(base + j);
        return w;
    endfunction

    // Take 24 bytes off the model queue: three consecutive bytes per pixel,
    // first byte in the pixel's top byte.
    function automatic logic [191:0] popBeat();
        logic [191:0] px;
        logic [7:0]   b0, b1, b2;
        px = '0;
        for (int p = 0; p < 8; p++) begin
            b0 = pend.pop_front();
            b1 = pend.pop_front();
            b2 = pend.pop_front();
            px[24*p +: 24] = {b0, b1, b2};
        end
        return px;
    endfunction

    task automatic pushExp(input logic [191:0] r, input logic s, input logic e);
        expRgb.push_back(r);
        expSof.push_back(s);
        expEol.push_back(e);
    endtask

    task automatic modelAccept(input logic [255:0] d, input logic u, input logic l);
        logic [191:0] b;
        if (u && mWordIdx != 0) begin
            mErr = 1'b1;
            pend.delete();
            mWordIdx = 0;
        end
        for (int j = 0; j < 32; j++) pend.push_back(d[8*j +: 8]);
        b = popBeat();
        if (l && mWordIdx < 2) begin
            mErr = 1'b1;
            pushExp(b, u, 1'b1);
            pend.delete();
            mWordIdx = 0;
        end else if (mWordIdx == 2) begin
            pushExp(b, u, 1'b0);
            b = popBeat();
            pushExp(b, 1'b0, l);
            mWordIdx = 0;
        end else begin
            pushExp(b, u, 1'b0);
            mWordIdx = mWordIdx + 1;
        end
    endtask

    // Monitor: samples on the falling edge, checks taken beats against the
    // model, checks stall behaviour and feeds accepted words to the model.
    always @(negedge aclk) begin
        if (monOn) begin
            if (!aresetn) begin
                pend.delete();
                expRgb.delete();
                expSof.delete();
                expEol.delete();
                mWordIdx = 0;
                mErr = 1'b0;
                stallPrev = 1'b0;
            end else begin
                checkOutput("align_err", align_err, mErr);
                if (out_valid && !out_ready)
                    checkOutput("tready_stall", s_axis_tready, 1'b0);
                if (stallPrev) begin
                    checkOutput("hold_beat", {rgb_out, out_sof, out_eol}, prevOut);
                    checkOutput("hold_valid", out_valid, 1'b1);
                end
                stallPrev = out_valid && !out_ready;
                prevOut = {rgb_out, out_sof, out_eol};
                if (out_valid && out_ready) begin
                    if (expRgb.size() == 0) begin
                        checkOutput("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        checkOutput("beat_rgb", rgb_out, expRgb.pop_front());
                        checkOutput("beat_sof", out_sof, expSof.pop_front());
                        checkOutput("beat_eol", out_eol, expEol.pop_front());
                    end
                    gotRgb.push_back(rgb_out);
                    gotSof.push_back(out_sof);
                    gotEol.push_back(out_eol);
                end
                if (s_axis_tvalid && s_axis_tready) begin
                    modelAccept(s_axis_tdata, s_axis_tuser, s_axis_tlast);
                    accCycles.push_back(cyc);
                end
            end
        end
    end

    // Downstream ready pattern: 0 = always, 1 = toggle, 2 = random, else off.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Present one word after an optional idle gap and wait for it to be
    // accepted. Returns one step after the accepting edge.
    task automatic applyStimulus(input logic [255:0] d, input logic u,
                                 input logic l, input int gap);
        int  n;
        bit  accepted;
        s_axis_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge aclk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        accepted = 0;
        while (!accepted && n < 200) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                accepted = 1;
            end else begin
                @(posedge aclk);
                #1;
                n = n + 1;
            end
        end
        if (accepted) begin
            @(posedge aclk);
            #1;
        end else begin
            checkOutput("accept_timeout", 1'b0, 1'b1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        s_axis_tvalid = 1'b0;
        n = 0;
        while ((expRgb.size() != 0 || out_valid) && n < 300) begin
            @(posedge aclk);
            #1;
            n = n + 1;
        end
        checkOutput("drain_empty", expRgb.size(), 0);
    endtask

    task automatic clearGot();
        gotRgb.delete();
        gotSof.delete();
        gotEol.delete();
        accCycles.delete();
    endtask

    task automatic doReset();
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        clearGot();
    endtask

    task automatic sendLine(input int base);
        applyStimulus(mkWord(base), 1'b1, 1'b0, 0);
        applyStimulus(mkWord(base + 32), 1'b0, 1'b0, 0);
        applyStimulus(mkWord(base + 64), 1'b0, 1'b1, 0);
    endtask

    task automatic checkReferenceLine(input string tag);
        checkOutput({tag, "_count"}, gotRgb.size(), 4);
        checkOutput({tag, "_b0px0"}, gotRgb[0][23:0], 24'h000102);
        checkOutput({tag, "_b0sof"}, gotSof[0], 1'b1);
        checkOutput({tag, "_b1px0"}, gotRgb[1][23:0], 24'h18191A);
        checkOutput({tag, "_b2px0"}, gotRgb[2][23:0], 24'h303132);
        checkOutput({tag, "_b3px7"}, gotRgb[3][191:168], 24'h5D5E5F);
        checkOutput({tag, "_b3eol"}, gotEol[3], 1'b1);
        checkOutput({tag, "_b2eol"}, gotEol[2], 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] w;
        logic         u;
        logic         l;
        int           grp;

        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tvalid = 1'b0;
        readyMode     = 0;

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        monOn = 1;
        @(negedge aclk);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_sof", out_sof, 1'b0);
        checkOutput("rst_eol", out_eol, 1'b0);
        checkOutput("rst_err", align_err, 1'b0);
        checkOutput("rst_rgb", rgb_out, 192'b0);
        checkOutput("rst_tready", s_axis_tready, 1'b0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        clearGot();

        // Single line, out_ready high
        $display("[TB] single line");
        sendLine(0);
        drain();
        checkReferenceLine("line");
        checkOutput("line_err", align_err, 1'b0);

        // Same line with out_ready toggling
        $display("[TB] single line, toggling ready");
        doReset();
        readyMode = 1;
        sendLine(0);
        drain();
        checkReferenceLine("toggle");
        readyMode = 0;

        // Two back-to-back lines with tvalid continuously high
        $display("[TB] two lines back to back");
        doReset();
        sendLine(0);
        applyStimulus(mkWord(96), 1'b0, 1'b0, 0);
        applyStimulus(mkWord(128), 1'b0, 1'b0, 0);
        applyStimulus(mkWord(160), 1'b0, 1'b1, 0);
        drain();
        checkOutput("b2b_beats", gotRgb.size(), 8);
        checkOutput("b2b_words", accCycles.size(), 6);
        checkOutput("b2b_span", accCycles[5] - accCycles[0], 6);
        checkOutput("b2b_eol3", gotEol[3], 1'b1);
        checkOutput("b2b_eol7", gotEol[7], 1'b1);
        checkOutput("b2b_eol4", gotEol[4], 1'b0);

        // tuser on the second word of a line
        $display("[TB] tuser resync");
        doReset();
        applyStimulus(mkWord(0), 1'b1, 1'b0, 0);
        checkOutput("sync_err_pre", align_err, 1'b0);
        applyStimulus(mkWord(100), 1'b1, 1'b0, 0);
        checkOutput("sync_err_post", align_err, 1'b1);
        applyStimulus(mkWord(132), 1'b0, 1'b0, 0);
        applyStimulus(mkWord(164), 1'b0, 1'b1, 0);
        drain();
        checkOutput("sync_beats", gotRgb.size(), 5);
        checkOutput("sync_sof1", gotSof[1], 1'b1);
        checkOutput("sync_px1", gotRgb[1][23:0], 24'h646566);
        checkOutput("sync_px2", gotRgb[2][23:0], 24'h7C7D7E);
        checkOutput("sync_eol4", gotEol[4], 1'b1);

        // tlast on w1
        $display("[TB] early tlast");
        doReset();
        applyStimulus(mkWord(0), 1'b1, 1'b0, 0);
        applyStimulus(mkWord(32), 1'b0, 1'b1, 0);
        checkOutput("early_err", align_err, 1'b1);
        applyStimulus(mkWord(200), 1'b0, 1'b0, 0);
        applyStimulus(mkWord(232), 1'b0, 1'b0, 0);
        applyStimulus(mkWord(8), 1'b0, 1'b1, 0);
        drain();
        checkOutput("early_beats", gotRgb.size(), 6);
        checkOutput("early_eol1", gotEol[1], 1'b1);
        checkOutput("early_px2", gotRgb[2][23:0], 24'hC8C9CA);

        // Reset pulled in S2 with a beat pending
        $display("[TB] reset mid-line");
        doReset();
        applyStimulus(mkWord(0), 1'b0, 1'b1, 0);
        applyStimulus(mkWord(10), 1'b0, 1'b0, 0);
        applyStimulus(mkWord(42), 1'b0, 1'b0, 0);
        checkOutput("mid_valid_pre", out_valid, 1'b1);
        checkOutput("mid_err_pre", align_err, 1'b1);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("mid_valid", out_valid, 1'b0);
        checkOutput("mid_err", align_err, 1'b0);
        checkOutput("mid_tready", s_axis_tready, 1'b1);
        @(posedge aclk);
        #1;
        clearGot();
        sendLine(0);
        drain();
        checkReferenceLine("fresh");

        // Randomised traffic against the model
        $display("[TB] random traffic");
        doReset();
        readyMode = 2;
        grp = 0;
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom;
            u = ($urandom_range(0, 29) == 0) || (i == 0);
            l = (grp == 2);
            if ($urandom_range(0, 14) == 0) l = ~l;
            grp = (grp == 2) ? 0 : grp + 1;
            applyStimulus(w, u, l, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        end
        drain();
        readyMode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
